// File: rtl/rename_port_scheduler_if.sv
// Bundle between dispatch requesters / register file (master side) and the
// rename port scheduler (slave side).
interface rename_port_scheduler_if #(
   parameter int unsigned NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_is_simple;
   logic [NUM_REQ-1:0]   req_is_branch_or_store;
   logic [NUM_REQ-1:0]   req_op1_flag;
   logic [NUM_REQ-1:0]   req_op2_flag;
   logic [4*NUM_REQ-1:0] req_id;
   logic [4*NUM_REQ-1:0] req_rd_rename;
   logic [5*NUM_REQ-1:0] req_op1_reg;
   logic [5*NUM_REQ-1:0] req_op2_reg;
   logic [5*NUM_REQ-1:0] req_rd;

   logic        rename_need;
   logic        rename_need_ins_is_simple;
   logic        rename_need_ins_is_branch_or_store;
   logic        operand_1_flag;
   logic        operand_2_flag;
   logic [3:0]  rename_need_id;
   logic [3:0]  new_ins_rd_rename;
   logic [4:0]  operand_1_reg;
   logic [4:0]  operand_2_reg;
   logic [4:0]  new_ins_rd;

   logic        rename_finish;
   logic        simple_ins_commit;
   logic [3:0]  rename_finish_id;
   logic [3:0]  simple_ins_rename;
   logic        operand_1_busy;
   logic        operand_2_busy;
   logic [3:0]  operand_1_rename;
   logic [3:0]  operand_2_rename;
   logic [31:0] operand_1_data_from_reg;
   logic [31:0] operand_2_data_from_reg;

   logic [NUM_REQ-1:0] req_ack;
   logic        ack_op1_busy;
   logic        ack_op2_busy;
   logic [3:0]  ack_op1_rename;
   logic [3:0]  ack_op2_rename;
   logic [31:0] ack_op1_data;
   logic [31:0] ack_op2_data;

   modport master (
      output req_valid, req_is_simple, req_is_branch_or_store, req_op1_flag, req_op2_flag,
             req_id, req_rd_rename, req_op1_reg, req_op2_reg, req_rd,
             rename_finish, simple_ins_commit, rename_finish_id, simple_ins_rename,
             operand_1_busy, operand_2_busy, operand_1_rename, operand_2_rename,
             operand_1_data_from_reg, operand_2_data_from_reg,
      input  rename_need, rename_need_ins_is_simple, rename_need_ins_is_branch_or_store,
             operand_1_flag, operand_2_flag, rename_need_id, new_ins_rd_rename,
             operand_1_reg, operand_2_reg, new_ins_rd,
             req_ack, ack_op1_busy, ack_op2_busy, ack_op1_rename, ack_op2_rename,
             ack_op1_data, ack_op2_data
   );

   modport slave (
      input  req_valid, req_is_simple, req_is_branch_or_store, req_op1_flag, req_op2_flag,
             req_id, req_rd_rename, req_op1_reg, req_op2_reg, req_rd,
             rename_finish, simple_ins_commit, rename_finish_id, simple_ins_rename,
             operand_1_busy, operand_2_busy, operand_1_rename, operand_2_rename,
             operand_1_data_from_reg, operand_2_data_from_reg,
      output rename_need, rename_need_ins_is_simple, rename_need_ins_is_branch_or_store,
             operand_1_flag, operand_2_flag, rename_need_id, new_ins_rd_rename,
             operand_1_reg, operand_2_reg, new_ins_rd,
             req_ack, ack_op1_busy, ack_op2_busy, ack_op1_rename, ack_op2_rename,
             ack_op1_data, ack_op2_data
   );
endinterface

// File: rtl/rename_port_scheduler.sv
// Round-robin arbiter sharing the register file rename/operand-lookup port
// between dispatch requesters; one request outstanding at a time.
module rename_port_scheduler #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   register_flush,
   rename_port_scheduler_if.slave bus,
   output logic                   busy,
   output logic                   timeout_err
);
   localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

   state_e               state_q;
   logic [IDX_W-1:0]     gidx_q, rr_q, rr_d, grant_c;
   logic [CNT_W-1:0]     cnt_q;
   logic                 found_c, match_c;
   logic                 need_q, simple_q, bos_q, f1_q, f2_q, busy_q, terr_q;
   logic [TAG_W-1:0]     id_q, rdren_q;
   logic [REG_W-1:0]     op1reg_q, op2reg_q, rd_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic                 a1b_q, a2b_q;
   logic [TAG_W-1:0]     a1r_q, a2r_q;
   logic [31:0]          a1d_q, a2d_q;
   logic                 sel_simple, sel_bos, sel_f1, sel_f2;
   logic [TAG_W-1:0]     sel_id, sel_rdren;
   logic [REG_W-1:0]     sel_op1, sel_op2, sel_rd;
   int unsigned          cand;

   // First valid requester at or after rr_q, with wrap, and its bundle.
   always_comb begin
      found_c    = 1'b0;
      grant_c    = '0;
      cand       = 0;
      sel_simple = 1'b0;
      sel_bos    = 1'b0;
      sel_f1     = 1'b0;
      sel_f2     = 1'b0;
      sel_id     = '0;
      sel_rdren  = '0;
      sel_op1    = '0;
      sel_op2    = '0;
      sel_rd     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(rr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found_c && bus.req_valid[IDX_W'(cand)]) begin
            found_c = 1'b1;
            grant_c = IDX_W'(cand);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == grant_c) begin
            sel_simple = bus.req_is_simple[i];
            sel_bos    = bus.req_is_branch_or_store[i];
            sel_f1     = bus.req_op1_flag[i];
            sel_f2     = bus.req_op2_flag[i];
            sel_id     = bus.req_id[i*TAG_W +: TAG_W];
            sel_rdren  = bus.req_rd_rename[i*TAG_W +: TAG_W];
            sel_op1    = bus.req_op1_reg[i*REG_W +: REG_W];
            sel_op2    = bus.req_op2_reg[i*REG_W +: REG_W];
            sel_rd     = bus.req_rd[i*REG_W +: REG_W];
         end
      end
      rr_d = (32'(grant_c) + 1 >= NUM_REQ) ? '0 : grant_c + IDX_W'(1);
   end

   // Simple ops complete on the commit tag, everything else on the ROB tag.
   assign match_c = simple_q ? (bus.simple_ins_commit && (bus.simple_ins_rename == rdren_q))
                             : (bus.rename_finish && (bus.rename_finish_id == id_q));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         gidx_q   <= '0;
         rr_q     <= '0;
         cnt_q    <= '0;
         need_q   <= 1'b0;
         simple_q <= 1'b0;
         bos_q    <= 1'b0;
         f1_q     <= 1'b0;
         f2_q     <= 1'b0;
         id_q     <= '0;
         rdren_q  <= '0;
         op1reg_q <= '0;
         op2reg_q <= '0;
         rd_q     <= '0;
         ack_q    <= '0;
         a1b_q    <= 1'b0;
         a2b_q    <= 1'b0;
         a1r_q    <= '0;
         a2r_q    <= '0;
         a1d_q    <= '0;
         a2d_q    <= '0;
         busy_q   <= 1'b0;
         terr_q   <= 1'b0;
      end else if (rdy) begin
         if (register_flush) begin
            state_q <= IDLE;
            need_q  <= 1'b0;
            ack_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            need_q <= 1'b0;
            ack_q  <= '0;
            unique case (state_q)
               IDLE: if (found_c) begin
                  gidx_q   <= grant_c;
                  rr_q     <= rr_d;
                  simple_q <= sel_simple;
                  bos_q    <= sel_bos;
                  f1_q     <= sel_f1;
                  f2_q     <= sel_f2;
                  id_q     <= sel_id;
                  rdren_q  <= sel_rdren;
                  op1reg_q <= sel_op1;
                  op2reg_q <= sel_op2;
                  rd_q     <= sel_rd;
                  need_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= ISSUE;
               end
               ISSUE: begin
                  cnt_q   <= '0;
                  state_q <= WAIT;
               end
               WAIT: begin
                  if (match_c) begin
                     if (!simple_q) begin
                        a1b_q <= bus.operand_1_busy;
                        a2b_q <= bus.operand_2_busy;
                        a1r_q <= bus.operand_1_rename;
                        a2r_q <= bus.operand_2_rename;
                        a1d_q <= bus.operand_1_data_from_reg;
                        a2d_q <= bus.operand_2_data_from_reg;
                     end
                     ack_q   <= NUM_REQ'(1) << gidx_q;
                     cnt_q   <= '0;
                     state_q <= ACK;
                  end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                     terr_q  <= 1'b1;
                     cnt_q   <= '0;
                     need_q  <= 1'b1;
                     state_q <= ISSUE;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ACK: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.rename_need                        = need_q;
   assign bus.rename_need_ins_is_simple          = simple_q;
   assign bus.rename_need_ins_is_branch_or_store = bos_q;
   assign bus.operand_1_flag                     = f1_q;
   assign bus.operand_2_flag                     = f2_q;
   assign bus.rename_need_id                     = id_q;
   assign bus.new_ins_rd_rename                  = rdren_q;
   assign bus.operand_1_reg                      = op1reg_q;
   assign bus.operand_2_reg                      = op2reg_q;
   assign bus.new_ins_rd                         = rd_q;
   assign bus.req_ack                            = ack_q;
   assign bus.ack_op1_busy                       = a1b_q;
   assign bus.ack_op2_busy                       = a2b_q;
   assign bus.ack_op1_rename                     = a1r_q;
   assign bus.ack_op2_rename                     = a2r_q;
   assign bus.ack_op1_data                       = a1d_q;
   assign bus.ack_op2_data                       = a2d_q;
   assign busy                                   = busy_q;
   assign timeout_err                            = terr_q;
endmodule

// File: tb/tb_rename_port_scheduler.sv
// Directed self-checking bench for rename_port_scheduler (NUM_REQ=2, TIMEOUT=15).
module tb_rename_port_scheduler;
   logic clk = 1'b0;
   logic rst, rdy, register_flush;
   logic busy, timeout_err;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rename_port_scheduler_if #(.NUM_REQ(2)) bus ();

   rename_port_scheduler #(.NUM_REQ(2), .TIMEOUT(15)) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .register_flush(register_flush),
      .bus           (bus.slave),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic simple, input logic [3:0] id,
                          input logic [3:0] rdr, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd);
      bus.req_valid[i]              = 1'b1;
      bus.req_is_simple[i]          = simple;
      bus.req_is_branch_or_store[i] = 1'b0;
      bus.req_op1_flag[i]           = 1'b1;
      bus.req_op2_flag[i]           = 1'b1;
      bus.req_id[i*4 +: 4]          = id;
      bus.req_rd_rename[i*4 +: 4]   = rdr;
      bus.req_op1_reg[i*5 +: 5]     = r1;
      bus.req_op2_reg[i*5 +: 5]     = r2;
      bus.req_rd[i*5 +: 5]          = rd;
   endtask

   // Present one register-file response for a single cycle.
   task automatic drive_resp(input logic fin, input logic [3:0] fid, input logic sc,
                             input logic [3:0] stag, input logic b1, input logic [3:0] r1,
                             input logic [31:0] d1, input logic b2, input logic [3:0] r2,
                             input logic [31:0] d2);
      bus.rename_finish           = fin;
      bus.rename_finish_id        = fid;
      bus.simple_ins_commit       = sc;
      bus.simple_ins_rename       = stag;
      bus.operand_1_busy          = b1;
      bus.operand_1_rename        = r1;
      bus.operand_1_data_from_reg = d1;
      bus.operand_2_busy          = b2;
      bus.operand_2_rename        = r2;
      bus.operand_2_data_from_reg = d2;
      tick();
      bus.rename_finish     = 1'b0;
      bus.simple_ins_commit = 1'b0;
   endtask

   task automatic wait_need(input string tag);
      int k = 0;
      while (!bus.rename_need && k < 40) begin
         tick();
         k++;
      end
      check_eq(tag, 32'(bus.rename_need), 32'd1);
   endtask

   // Full grant/response/ack cycle expecting requester exp_idx with ROB tag id.
   task automatic do_txn(input int exp_idx, input logic [3:0] id, input logic [31:0] data);
      wait_need("txn_need");
      check_eq("txn_grant_id", 32'(bus.rename_need_id), 32'(id));
      tick();
      drive_resp(1'b1, id, 1'b0, 4'd0, 1'b1, id, data, 1'b0, 4'd0, ~data);
      check_eq("txn_ack", 32'(bus.req_ack), 32'd1 << exp_idx);
      check_eq("txn_ack_data", bus.ack_op1_data, data);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      logic te_mid;
      rst = 1'b0; rdy = 1'b1; register_flush = 1'b0;
      bus.req_valid = '0; bus.req_is_simple = '0; bus.req_is_branch_or_store = '0;
      bus.req_op1_flag = '0; bus.req_op2_flag = '0; bus.req_id = '0; bus.req_rd_rename = '0;
      bus.req_op1_reg = '0; bus.req_op2_reg = '0; bus.req_rd = '0;
      bus.rename_finish = 1'b0; bus.simple_ins_commit = 1'b0;
      bus.rename_finish_id = '0; bus.simple_ins_rename = '0;
      bus.operand_1_busy = 1'b0; bus.operand_2_busy = 1'b0;
      bus.operand_1_rename = '0; bus.operand_2_rename = '0;
      bus.operand_1_data_from_reg = '0; bus.operand_2_data_from_reg = '0;

      // Reset values
      tick(); tick();
      check_eq("rst_need", 32'(bus.rename_need), 32'd0);
      check_eq("rst_ack", 32'(bus.req_ack), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_terr", 32'(timeout_err), 32'd0);
      rst = 1'b1;

      // Single non-simple request
      set_req(0, 1'b0, 4'd3, 4'd2, 5'd5, 5'd6, 5'd10);
      tick();
      check_eq("t1_need_hi", 32'(bus.rename_need), 32'd1);
      check_eq("t1_id", 32'(bus.rename_need_id), 32'd3);
      check_eq("t1_op1_reg", 32'(bus.operand_1_reg), 32'd5);
      check_eq("t1_op2_reg", 32'(bus.operand_2_reg), 32'd6);
      check_eq("t1_rd", 32'(bus.new_ins_rd), 32'd10);
      check_eq("t1_busy", 32'(busy), 32'd1);
      tick();
      check_eq("t1_need_lo", 32'(bus.rename_need), 32'd0);
      drive_resp(1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'h1234);
      check_eq("t1_ack", 32'(bus.req_ack), 32'd1);
      check_eq("t1_op1_busy", 32'(bus.ack_op1_busy), 32'd1);
      check_eq("t1_op1_ren", 32'(bus.ack_op1_rename), 32'd7);
      check_eq("t1_op2_busy", 32'(bus.ack_op2_busy), 32'd0);
      check_eq("t1_op2_data", bus.ack_op2_data, 32'h1234);
      bus.req_valid = '0;
      tick();
      check_eq("t1_ack_off", 32'(bus.req_ack), 32'd0);
      check_eq("t1_idle", 32'(busy), 32'd0);

      // Round robin from rr_ptr=0
      rst = 1'b0; tick(); rst = 1'b1;
      set_req(0, 1'b0, 4'd1, 4'd0, 5'd1, 5'd2, 5'd3);
      set_req(1, 1'b0, 4'd2, 4'd0, 5'd4, 5'd5, 5'd6);
      for (int t = 0; t < 6; t++) do_txn(t % 2, 4'(t % 2 + 1), 32'h100 + 32'(t));
      bus.req_valid = '0;
      // Advance rr_ptr to 1, then the same pattern with roles swapped
      set_req(0, 1'b0, 4'd1, 4'd0, 5'd1, 5'd2, 5'd3);
      do_txn(0, 4'd1, 32'h200);
      set_req(1, 1'b0, 4'd2, 4'd0, 5'd4, 5'd5, 5'd6);
      for (int t = 0; t < 6; t++) do_txn((t + 1) % 2, 4'((t + 1) % 2 + 1), 32'h300 + 32'(t));
      bus.req_valid = '0;

      // Simple request: foreign rename_finish ignored, ack data retained
      set_req(0, 1'b0, 4'd4, 4'd0, 5'd1, 5'd1, 5'd1);
      do_txn(0, 4'd4, 32'hCAFE0001);
      bus.req_valid = '0;
      set_req(0, 1'b1, 4'd2, 4'd9, 5'd7, 5'd8, 5'd9);
      wait_need("simple_need");
      check_eq("simple_flag", 32'(bus.rename_need_ins_is_simple), 32'd1);
      check_eq("simple_rdren", 32'(bus.new_ins_rd_rename), 32'd9);
      tick();
      drive_resp(1'b1, 4'd11, 1'b0, 4'd0, 1'b0, 4'd3, 32'hBAD, 1'b0, 4'd0, 32'hBAD);
      check_eq("simple_foreign_ignored", 32'(bus.req_ack), 32'd0);
      check_eq("simple_still_busy", 32'(busy), 32'd1);
      drive_resp(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 4'd3, 32'hDEAD, 1'b0, 4'd0, 32'hDEAD);
      check_eq("simple_ack", 32'(bus.req_ack), 32'd1);
      check_eq("simple_retain", bus.ack_op1_data, 32'hCAFE0001);
      bus.req_valid = '0;
      tick();

      // Timeout after 15 WAIT cycles, then normal completion
      set_req(0, 1'b0, 4'd4, 4'd0, 5'd2, 5'd3, 5'd4);
      wait_need("to_need");
      n = 0; te_mid = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 15) te_mid = timeout_err;
         if (bus.rename_need) begin n = k; break; end
      end
      check_eq("to_repulse_cycles", 32'(n), 32'd16);
      check_eq("to_err_before", 32'(te_mid), 32'd0);
      check_eq("to_err_set", 32'(timeout_err), 32'd1);
      check_eq("to_reissue_id", 32'(bus.rename_need_id), 32'd4);
      tick();
      drive_resp(1'b1, 4'd4, 1'b0, 4'd0, 1'b1, 4'd4, 32'h55, 1'b0, 4'd0, 32'h66);
      check_eq("to_ack", 32'(bus.req_ack), 32'd1);
      check_eq("to_ack_data", bus.ack_op2_data, 32'h66);
      check_eq("to_err_sticky", 32'(timeout_err), 32'd1);
      bus.req_valid = '0;
      tick();

      // Flush in WAIT
      set_req(0, 1'b0, 4'd5, 4'd0, 5'd1, 5'd2, 5'd3);
      wait_need("fw_need");
      tick();
      register_flush = 1'b1; bus.req_valid = '0;
      tick();
      register_flush = 1'b0;
      check_eq("fw_idle", 32'(busy), 32'd0);
      check_eq("fw_need_lo", 32'(bus.rename_need), 32'd0);
      check_eq("fw_no_ack", 32'(bus.req_ack), 32'd0);
      tick();
      check_eq("fw_no_ack_later", 32'(bus.req_ack), 32'd0);

      // Flush in ISSUE, then a normal request
      set_req(0, 1'b0, 4'd6, 4'd0, 5'd1, 5'd2, 5'd3);
      wait_need("fi_need");
      register_flush = 1'b1; bus.req_valid = '0;
      tick();
      register_flush = 1'b0;
      check_eq("fi_idle", 32'(busy), 32'd0);
      check_eq("fi_need_lo", 32'(bus.rename_need), 32'd0);
      check_eq("fi_no_ack", 32'(bus.req_ack), 32'd0);
      set_req(0, 1'b0, 4'd7, 4'd0, 5'd1, 5'd2, 5'd3);
      do_txn(0, 4'd7, 32'h777);
      bus.req_valid = '0;

      // rdy low for 5 cycles in ISSUE, then reset during ACK
      set_req(1, 1'b0, 4'd8, 4'd0, 5'd9, 5'd10, 5'd11);
      wait_need("rdy_need");
      rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("rdy_frozen_need", 32'(bus.rename_need), 32'd1);
         check_eq("rdy_frozen_busy", 32'(busy), 32'd1);
      end
      rdy = 1'b1;
      tick();
      check_eq("rdy_resume_wait", 32'(bus.rename_need), 32'd0);
      drive_resp(1'b1, 4'd8, 1'b0, 4'd0, 1'b1, 4'd5, 32'hABCD, 1'b1, 4'd6, 32'hEF01);
      check_eq("rdy_ack", 32'(bus.req_ack), 32'd2);
      rst = 1'b0; bus.req_valid = '0;
      tick();
      check_eq("ra_need", 32'(bus.rename_need), 32'd0);
      check_eq("ra_ack", 32'(bus.req_ack), 32'd0);
      check_eq("ra_busy", 32'(busy), 32'd0);
      check_eq("ra_terr", 32'(timeout_err), 32'd0);
      check_eq("ra_id", 32'(bus.rename_need_id), 32'd0);
      check_eq("ra_op1_reg", 32'(bus.operand_1_reg), 32'd0);
      check_eq("ra_ack_data1", bus.ack_op1_data, 32'd0);
      check_eq("ra_ack_data2", bus.ack_op2_data, 32'd0);
      check_eq("ra_ack_ren", 32'(bus.ack_op1_rename), 32'd0);
      rst = 1'b1;
      tick();
      check_eq("ra_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
